// File: rtl/circular_shift_pkg.sv
// Shared types and the power-of-two rotate helper used by every pipeline stage.
package circular_shift_pkg;

    typedef enum logic {
        ROT_LEFT  = 1'b0,
        ROT_RIGHT = 1'b1
    } rot_dir_t;

    // Widest word the helper handles; callers zero-extend into word_t and truncate back.
    localparam int unsigned MAX_W = 256;
    typedef logic [MAX_W-1:0] word_t;

    // Rotate the low w bits of data by 2^k in direction dir; bits above w are returned as 0.
    function automatic word_t rotate_by_pow2(input word_t data, input int unsigned w,
                                             input int unsigned k, input rot_dir_t dir);
        word_t       res;
        int unsigned s;
        res = '0;
        s   = (32'(1) << k) % w;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                if (dir == ROT_LEFT) begin
                    res[8'(i)] = data[8'((i + w - s) % w)];
                end else begin
                    res[8'(i)] = data[8'((i + s) % w)];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/circular_shift_stage.sv
// One pipeline slice: conditional rotate by 2^K, then a register bank loaded on i_en.
module circular_shift_stage #(
    parameter int unsigned W  = 8,
    parameter int unsigned SW = 3,
    parameter int unsigned K  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_valid,
    input  logic [W-1:0]  i_data,
    input  logic [SW-1:0] i_shift,
    input  logic          i_dir,
    output logic          o_valid,
    output logic [W-1:0]  o_data,
    output logic [SW-1:0] o_shift,
    output logic          o_dir
);
    import circular_shift_pkg::*;

    logic [W-1:0]  w_rot;
    logic [W-1:0]  w_next;
    logic          r_valid;
    logic [W-1:0]  r_data;
    logic [SW-1:0] r_shift;
    logic          r_dir;

    assign w_rot  = W'(rotate_by_pow2(word_t'(i_data), W, K, rot_dir_t'(i_dir)));
    assign w_next = i_shift[K] ? w_rot : i_data;

    // Register slice; holds everything when the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_shift <= '0;
            r_dir   <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_next;
            r_shift <= i_shift;
            r_dir   <= i_dir;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_shift = r_shift;
    assign o_dir   = r_dir;

endmodule

// File: rtl/circular_shifter_pipelined.sv
// Pipelined barrel rotator: SW chained stages, each rotating by one power of two, with a global stall.
module circular_shifter_pipelined #(
    parameter  int unsigned W  = 8,
    localparam int unsigned SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [W-1:0]  up_data,
    input  logic [SW-1:0] up_shift,
    input  logic          up_dir,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [W-1:0]  down_data
);

    logic          w_valid [SW+1];
    logic [W-1:0]  w_data  [SW+1];
    logic [SW-1:0] w_shift [SW+1];
    logic          w_dir   [SW+1];
    logic          w_adv;
    logic          w_unused;

    assign w_valid[0] = up_valid;
    assign w_data[0]  = up_data;
    assign w_shift[0] = up_shift;
    assign w_dir[0]   = up_dir;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        circular_shift_stage #(
            .W  (W),
            .SW (SW),
            .K  (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_adv),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .i_shift (w_shift[k]),
            .i_dir   (w_dir[k]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1]),
            .o_shift (w_shift[k+1]),
            .o_dir   (w_dir[k+1])
        );
    end

    // Whole pipeline moves together; bubbles are never collapsed.
    assign w_adv      = !w_valid[SW] || down_ready;
    assign up_ready   = w_adv;
    assign down_valid = w_valid[SW];
    assign down_data  = w_data[SW];
    assign w_unused   = ^{w_shift[SW], w_dir[SW]};

endmodule

// File: tb/tb_circular_shifter_pipelined.sv
// Scoreboard bench for circular_shifter_pipelined at W=8 with directed, hand-computed vectors.
module tb_circular_shifter_pipelined;

    localparam int unsigned W  = 8;
    localparam int unsigned SW = 3;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
        bit           lat_chk;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          up_valid;
    logic          up_ready;
    logic [W-1:0]  up_data;
    logic [SW-1:0] up_shift;
    logic          up_dir;
    logic          down_valid;
    logic          down_ready;
    logic [W-1:0]  down_data;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   lat_mode = 1'b1;

    circular_shifter_pipelined #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_shift   (up_shift),
        .up_dir     (up_dir),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every output handshake pops one expected entry.
    always @(negedge clk) begin
        if (!rst && down_valid && down_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %0h expected none (cyc %0d)", down_data, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("down_data", 32'(down_data), 32'(e.data));
                if (e.lat_chk) check("latency", 32'(cyc - e.cyc), 32'(SW));
            end
        end
    end

    // Present one word; returns after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s, input logic dir,
                        input logic [W-1:0] exp_d);
        bit done;
        done     = 1'b0;
        up_valid = 1'b1;
        up_data  = d;
        up_shift = s;
        up_dir   = dir;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (up_ready) begin
                exp_t e;
                e.data    = exp_d;
                e.cyc     = cyc;
                e.lat_chk = lat_mode;
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'(0), 32'(1));
        up_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'(0));
    endtask

    initial begin
        logic [W-1:0] held;
        bit           seen;
        rst        = 1'b1;
        up_valid   = 1'b0;
        up_data    = '0;
        up_shift   = '0;
        up_dir     = 1'b0;
        down_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_down_valid", 32'(down_valid), 32'(0));
        check("rst_down_data", 32'(down_data), 32'(0));
        check("rst_up_ready", 32'(up_ready), 32'(1));
        @(posedge clk);
        #1;

        // Single transactions, left then right.
        send(8'b10110101, 3'd3, 1'b0, 8'b10101101);
        drain();
        send(8'b10110101, 3'd3, 1'b1, 8'b10110110);
        drain();

        // Back-to-back walking one; latency check also proves no gaps.
        for (int i = 0; i < 8; i++) send(8'b00000001, 3'(i), 1'b0, 8'(1 << i));
        drain();

        // Boundary shifts.
        send(8'b11010001, 3'd7, 1'b0, 8'b11101000);
        send(8'b11010001, 3'd1, 1'b1, 8'b11101000);
        send(8'b11010001, 3'd0, 1'b0, 8'b11010001);
        send(8'b11010001, 3'd0, 1'b1, 8'b11010001);
        drain();

        // Backpressure: hold output for 5 cycles.
        lat_mode   = 1'b0;
        down_ready = 1'b0;
        send(8'b11100000, 3'd3, 1'b1, 8'b00011100);
        send(8'b01110000, 3'd3, 1'b0, 8'b10000011);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = down_valid;
        end
        check("bp_valid_seen", 32'(seen), 32'(1));
        held = down_data;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_data_stable", 32'(down_data), 32'(held));
            check("bp_up_ready", 32'(up_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        down_ready = 1'b1;
        drain();

        // Reset with a full pipeline; flushed words must never appear.
        down_ready = 1'b0;
        send(8'b00001111, 3'd1, 1'b0, 8'b00011110);
        send(8'b00110011, 3'd2, 1'b0, 8'b11001100);
        send(8'b01010101, 3'd1, 1'b1, 8'b10101010);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_down_valid", 32'(down_valid), 32'(0));
        @(posedge clk);
        #1;
        down_ready = 1'b1;
        lat_mode   = 1'b1;
        send(8'b00100110, 3'd3, 1'b0, 8'b00110001);
        drain();
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/circular_shifter_pipelined.md
Name: circular_shifter_pipelined

Overview:
- Parametrised, pipelined barrel rotator. Rotates a W-bit word left or right by a per-transaction variable amount.
- Successor to the fixed N/S combinational circular-shift blocks; those blocks use a compile-time shift and have no timing.
- Uses a valid/ready handshake on both sides. Sits between streaming datapath stages; one transaction per cycle at full throughput.

Parameters:
- W, 8, data width; must be a power of two, at least 2.
- SW, $clog2(W), shift-amount width and number of pipeline stages; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- up_valid  input  1  upstream transaction present.
- up_ready  output  1  block accepts upstream transaction this cycle.
- up_data  input  W  word to rotate.
- up_shift  input  SW  rotate amount, 0..W-1.
- up_dir  input  1  0 = rotate left, 1 = rotate right.
- down_valid  output  1  rotated result present.
- down_ready  input  1  downstream accepts result.
- down_data  output  W  rotated word.

Behaviour:
- Reset is synchronous, active-high: `rst` sampled high at a rising `clk` edge.
- Reset values:
  - all stage valid bits = 0, so down_valid = 0;
  - stage data/shift/dir registers = 0, so down_data = 0;
  - up_ready follows its combinational rule below.
- Pipeline has SW register stages. Stage k (k = 0..SW-1) rotates its input by 2^k positions in direction dir when shift bit k = 1, otherwise passes it unchanged.
- Each stage registers valid, data, the remaining shift bits and dir.
- down_data/down_valid come directly from stage SW-1; there is no combinational path from up_data to down_data.
- Global advance: adv = !down_valid || down_ready.
  - up_ready = adv (combinational; depends on down_ready).
  - When adv = 1, every stage loads from its predecessor, and stage 0 loads {up_valid, up_data, up_shift, up_dir}.
  - When adv = 0, all stages hold.
- Latency is exactly SW cycles from the accepting edge to down_valid, with down_ready held high. Throughput is 1 per cycle.
- Bubbles are not collapsed. An empty stage still advances only with adv; accepted order is preserved.
- Stalls: while down_valid = 1 and down_ready = 0, down_data stays stable and up_ready = 0.
- Upstream accepts only when up_valid && up_ready. When up_valid = 0 a bubble (valid = 0) is inserted on advance.
- Data registers of invalid stages may update freely. The bench checks down_data only when down_valid = 1.
- Shift boundaries:
  - shift = 0 outputs the input unchanged, for both directions;
  - shift = W-1 left equals rotate right by 1;
  - bits wrap MSB to LSB (left) or LSB to MSB (right); no bits are lost or zero-filled.
- Simultaneous accept on the input and consume on the output in the same cycle is legal and is the steady state.
- Reset mid-operation: all in-flight transactions are discarded with no output. down_valid is 0 on the cycle after the reset edge, and the first post-reset accept produces output SW cycles later.
- Arithmetic: rotation only, no carry or sign. Widths are exact W; there is no truncation path.

Decomposition:
- Shared package `circular_shift_pkg` holds:
  - enum `rot_dir_t` {ROT_LEFT = 1'b0, ROT_RIGHT = 1'b1};
  - function `rotate_by_pow2(data, k, dir)`, generic over W via parameterised class or a W-sized argument.
- Sub-module `circular_shift_stage` (parameters W, SW, K): one conditional 2^K rotate plus its register slice with enable.
- Top generates SW instances in a chain and owns the adv / up_ready logic.

Test Plan (W=8, SW=3):
- Reset then idle → down_valid = 0, down_data = 0, up_ready = 1.
- Single transaction:
  - data 10110101, shift 3, left → 10101101 exactly 3 cycles after accept;
  - same data, shift 3, right → 10110110.
- Back-to-back, 8 consecutive cycles, data 00000001 with shifts 0..7 left → outputs 00000001, 00000010 … 10000000 in order on consecutive cycles, no gaps.
- Backpressure:
  - stream data 11100000 shift 3 right (→ 00011100) and data 01110000 shift 3 left (→ 10000011);
  - hold down_ready = 0 for 5 cycles while down_valid = 1 → down_data stable, up_ready = 0, no loss or duplication after release.
- Boundary: data 11010001, shift 7 left → 11101000; same data, shift 1 right → 11101000; shift 0 either direction → 11010001.
- Reset mid-stream: assert rst with 3 transactions in flight → down_valid = 0 on the next cycle and none of the flushed results ever appear. A post-reset transaction (00100110, shift 3 left → 00110001) arrives after 3 cycles.
